// File: rtl/servo_arbiter_if.sv
// Servo arbitration bus: three level requests with their angles in, one slewed
// angle plus ownership status out.
interface servo_arbiter_if;
  logic [2:0] req;
  logic [7:0] angle0;
  logic [7:0] angle1;
  logic [7:0] angle2;
  logic [7:0] angle_out;
  logic [2:0] grant;
  logic       settled;
  logic       preempt;

  modport master (
    output req, angle0, angle1, angle2,
    input  angle_out, grant, settled, preempt
  );

  modport slave (
    input  req, angle0, angle1, angle2,
    output angle_out, grant, settled, preempt
  );
endinterface

// File: rtl/servo_arbiter.sv
// Fixed-priority servo sharing (event 1 > event 2 > phase 2) with a post-release
// hold window and a slew limiter so the servo never jumps between owners.
module servo_arbiter #(
  parameter int SLEW_DIV    = 50000,
  parameter int HOLD_CYCLES = 25000000,
  parameter int IDLE_ANGLE  = 90,
  parameter int MAX_ANGLE   = 180
) (
  input  logic             clk,
  input  logic             sys_rst,
  servo_arbiter_if.slave   bus
);

  localparam int SW = (SLEW_DIV > 1)    ? $clog2(SLEW_DIV)    : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OWN0,
    ST_OWN1,
    ST_OWN2,
    ST_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          preempt_q, preempt_d;
  logic [SW-1:0] slew_q, slew_d;
  logic [7:0]    angle_q, angle_d;
  logic [7:0]    target_q, target_d;
  logic          settled_q, settled_d;
  logic [2:0]    grant_c;
  logic          any_req;
  logic [1:0]    win_idx;
  logic [1:0]    own_idx;
  logic          tick;

  function automatic logic [7:0] clamp(input logic [7:0] a);
    return (a > 8'(MAX_ANGLE)) ? 8'(MAX_ANGLE) : a;
  endfunction

  function automatic state_t own_state(input logic [1:0] idx);
    case (idx)
      2'd0:    return ST_OWN0;
      2'd1:    return ST_OWN1;
      default: return ST_OWN2;
    endcase
  endfunction

  // Lowest set request index wins; win_idx is don't-care when no request.
  // NOTE: every combinational output gets a default before any branch so no path
  // leaves it unassigned and a latch cannot be inferred.
  always_comb begin
    any_req = |bus.req;
    win_idx = 2'd0;
    if (bus.req[0])      win_idx = 2'd0;
    else if (bus.req[1]) win_idx = 2'd1;
    else if (bus.req[2]) win_idx = 2'd2;
  end

  always_comb begin
    case (state_q)
      ST_OWN1: own_idx = 2'd1;
      ST_OWN2: own_idx = 2'd2;
      default: own_idx = 2'd0;
    endcase
  end

  // State register, with the hold counter and preempt pulse that move with it.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  // Next-state logic. The hold counter is cleared whenever HOLD is not entered
  // or continued, so leaving HOLD on a new request also clears it.
  always_comb begin
    state_d   = state_q;
    preempt_d = 1'b0;
    hold_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) state_d = own_state(win_idx);
      end
      ST_OWN0, ST_OWN1, ST_OWN2: begin
        if (!any_req) begin
          state_d = ST_HOLD;
          hold_d  = HW'(HOLD_CYCLES - 1);
        end else if (win_idx != own_idx) begin
          // Either a higher-priority preemption or a direct handover downward.
          state_d   = own_state(win_idx);
          preempt_d = (win_idx < own_idx);
        end
      end
      ST_HOLD: begin
        if (any_req)              state_d = own_state(win_idx);
        else if (hold_q == '0)    state_d = ST_IDLE;
        else                      hold_d  = hold_q - HW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: grant depends only on the registered state.
  always_comb begin
    case (state_q)
      ST_OWN0: grant_c = 3'b001;
      ST_OWN1: grant_c = 3'b010;
      ST_OWN2: grant_c = 3'b100;
      default: grant_c = 3'b000;
    endcase
  end

  // Target follows the state being entered so it changes together with grant;
  // HOLD keeps whatever the last owner asked for.
  always_comb begin
    case (state_d)
      ST_IDLE: target_d = 8'(IDLE_ANGLE);
      ST_OWN0: target_d = clamp(bus.angle0);
      ST_OWN1: target_d = clamp(bus.angle1);
      ST_OWN2: target_d = clamp(bus.angle2);
      default: target_d = target_q;
    endcase
  end

  // Free-running slew divider; target changes never restart it.
  always_comb begin
    tick   = (slew_q == SW'(SLEW_DIV - 1));
    slew_d = tick ? '0 : slew_q + SW'(1);
  end

  always_comb begin
    angle_d = angle_q;
    if (tick && (angle_q < target_q))      angle_d = angle_q + 8'd1;
    else if (tick && (angle_q > target_q)) angle_d = angle_q - 8'd1;
    settled_d = (angle_d == target_d);
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      slew_q    <= '0;
      angle_q   <= 8'(IDLE_ANGLE);
      target_q  <= 8'(IDLE_ANGLE);
      settled_q <= 1'b1;
    end else begin
      slew_q    <= slew_d;
      angle_q   <= angle_d;
      target_q  <= target_d;
      settled_q <= settled_d;
    end
  end

  assign bus.angle_out = angle_q;
  assign bus.grant     = grant_c;
  assign bus.settled   = settled_q;
  assign bus.preempt   = preempt_q;

endmodule

// File: tb/tb_servo_arbiter.sv
// Directed bench for servo_arbiter: a behavioural ownership/slew model checked
// every cycle, plus literal expectations along the directed scenario.
module tb_servo_arbiter;

  localparam int SLEW = 4;
  localparam int HOLD = 20;
  localparam int IDLE = 90;
  localparam int MAXA = 180;

  logic clk = 1'b0;
  logic sys_rst;
  servo_arbiter_if bus ();

  servo_arbiter #(
    .SLEW_DIV(SLEW), .HOLD_CYCLES(HOLD), .IDLE_ANGLE(IDLE), .MAX_ANGLE(MAXA)
  ) dut (
    .clk(clk),
    .sys_rst(sys_rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  m_owner;      // -1 when nobody owns the servo
  bit  m_hold;
  int  m_hold_left;
  int  m_tgt, m_ang, m_phase;
  bit  m_pre, m_settled;
  bit  m_valid = 0;

  function automatic int req_angle(input int k);
    int a;
    a = (k == 0) ? int'(bus.angle0) : (k == 1) ? int'(bus.angle1) : int'(bus.angle2);
    return (a > MAXA) ? MAXA : a;
  endfunction

  always @(posedge clk) begin
    int w;
    if (sys_rst) begin
      m_owner = -1; m_hold = 0; m_hold_left = 0;
      m_tgt = IDLE; m_ang = IDLE; m_phase = 0;
      m_pre = 0; m_settled = 1; m_valid = 1;
    end else if (m_valid) begin
      w = bus.req[0] ? 0 : bus.req[1] ? 1 : bus.req[2] ? 2 : -1;
      if (m_phase == SLEW - 1) begin
        if (m_ang < m_tgt) m_ang++;
        else if (m_ang > m_tgt) m_ang--;
      end
      m_phase = (m_phase + 1) % SLEW;
      m_pre = 0;
      if (m_owner >= 0) begin
        if (w != m_owner) begin
          if (w >= 0) begin
            m_pre = (w < m_owner);
            m_owner = w;
          end else begin
            m_owner = -1; m_hold = 1; m_hold_left = HOLD - 1;
          end
        end
      end else if (m_hold) begin
        if (w >= 0) begin m_hold = 0; m_owner = w; end
        else if (m_hold_left == 0) m_hold = 0;
        else m_hold_left--;
      end else if (w >= 0) begin
        m_owner = w;
      end
      if (m_owner >= 0) m_tgt = req_angle(m_owner);
      else if (!m_hold) m_tgt = IDLE;
      m_settled = (m_ang == m_tgt);
    end
  end

  // Compare process: outputs are registered, so sample on the falling edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_angle",   int'(bus.angle_out), m_ang);
      check("model_grant",   int'(bus.grant), (m_owner >= 0) ? (1 << m_owner) : 0);
      check("model_settled", int'(bus.settled), int'(m_settled));
      check("model_preempt", int'(bus.preempt), int'(m_pre));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_angle(input string name, input int value, input int budget);
    for (int c = 0; c < budget && int'(bus.angle_out) != value; c++) @(negedge clk);
    check(name, int'(bus.angle_out), value);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_c, steps, prev;
    sys_rst = 1'b1;
    bus.req = 3'b000;
    bus.angle0 = 8'd0;
    bus.angle1 = 8'd0;
    bus.angle2 = 8'd0;
    repeat (3) @(negedge clk);
    sys_rst = 1'b0;

    // Idle for 100 cycles: parked and settled.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_angle",   int'(bus.angle_out), 90);
      check("idle_grant",   int'(bus.grant), 0);
      check("idle_settled", int'(bus.settled), 1);
    end

    // Phase 2 takes the servo and walks 90 -> 94, one degree every 4 cycles.
    bus.req = 3'b100;
    bus.angle2 = 8'd94;
    @(negedge clk);
    check("p2_grant", int'(bus.grant), 3'b100);
    prev = 90; steps = 0; last_c = 0;
    for (int c = 0; c < 60 && int'(bus.angle_out) != 94; c++) begin
      @(negedge clk);
      if (int'(bus.angle_out) != prev) begin
        check("p2_step_value", int'(bus.angle_out), prev + 1);
        if (steps > 0) check("p2_step_interval", c - last_c, 4);
        last_c = c; steps++; prev = int'(bus.angle_out);
      end
    end
    check("p2_reached", int'(bus.angle_out), 94);
    check("p2_steps", steps, 4);
    @(negedge clk);
    check("p2_settled", int'(bus.settled), 1);

    // Event 1 preempts: grant 001 with a single-cycle preempt pulse.
    bus.req = 3'b101;
    bus.angle0 = 8'd180;
    @(negedge clk);
    check("e1_grant", int'(bus.grant), 3'b001);
    check("e1_preempt_pulse", int'(bus.preempt), 1);
    @(negedge clk);
    check("e1_preempt_clear", int'(bus.preempt), 0);
    repeat (8) @(negedge clk);
    check("e1_ramp_up", int'(bus.angle_out > 8'd94), 1);

    // Out-of-range request clamps to 180 and the servo settles there.
    bus.angle0 = 8'd200;
    wait_angle("clamp_reach", 180, 500);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("clamp_limit", int'(bus.angle_out <= 8'd180), 1);
    end
    check("clamp_settled", int'(bus.settled), 1);

    // Event 1 drops while event 2 asks: direct handover, no preempt.
    bus.req = 3'b010;
    bus.angle1 = 8'd60;
    @(negedge clk);
    check("e2_grant", int'(bus.grant), 3'b010);
    check("e2_no_preempt", int'(bus.preempt), 0);
    wait_angle("e2_reach", 60, 700);

    // Release: hold 60 for the 20-cycle window, then ramp toward 90.
    bus.req = 3'b000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_grant", int'(bus.grant), 0);
      check("hold_angle", int'(bus.angle_out), 60);
    end
    wait_angle("hold_release", 61, 10);

    // Reset in the middle of the ramp.
    wait_angle("ramp_75", 75, 100);
    sys_rst = 1'b1;
    @(negedge clk);
    check("rst_angle",   int'(bus.angle_out), 90);
    check("rst_grant",   int'(bus.grant), 0);
    check("rst_settled", int'(bus.settled), 1);
    check("rst_preempt", int'(bus.preempt), 0);
    sys_rst = 1'b0;
    @(negedge clk);
    bus.req = 3'b010;
    bus.angle1 = 8'd100;
    @(negedge clk);
    check("post_rst_grant", int'(bus.grant), 3'b010);

    // Request during HOLD takes ownership at once.
    bus.req = 3'b000;
    repeat (5) @(negedge clk);
    bus.req = 3'b100;
    bus.angle2 = 8'd30;
    @(negedge clk);
    check("hold_reclaim_grant", int'(bus.grant), 3'b100);

    // Back to idle, then two requests rise together: lowest index wins.
    bus.req = 3'b000;
    repeat (30) @(negedge clk);
    check("idle_again_grant", int'(bus.grant), 0);
    bus.req = 3'b110;
    @(negedge clk);
    check("simul_grant", int'(bus.grant), 3'b010);
    check("simul_no_preempt", int'(bus.preempt), 0);
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
